// File: rtl/sync_counter_n.sv
// Parametrised synchronous modulo counter: up/down, parallel load with clamping,
// wrap or saturate at the range ends, combinational terminal count and registered wrap pulse.
module sync_counter_n #(
   parameter int     WIDTH    = 4,
   parameter longint MODULUS  = 16,
   parameter bit     SATURATE = 1'b0
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             count_enable,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             at_max, at_min, end_hit;
   logic [WIDTH-1:0] load_val;

   assign at_max   = (count_q == MAX_VAL);
   assign at_min   = (count_q == '0);
   assign end_hit  = up_down ? at_max : at_min;
   assign load_val = (d > MAX_VAL) ? MAX_VAL : d;

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = load_val;
      end else if (count_enable) begin
         wrap_d = end_hit;
         if (end_hit) begin
            // At a range end: either hold (saturate) or jump to the opposite end.
            if (!SATURATE) begin
               count_d = up_down ? '0 : MAX_VAL;
            end
         end else begin
            count_d = up_down ? (count_q + ONE) : (count_q - ONE);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign Q    = count_q;
   assign wrap = wrap_q;
   assign tc   = count_enable & end_hit;

endmodule
